// File: rtl/calc_datapath.sv
// Calculator operand/result datapath: nibble-wise operand entry, opcode latch,
// registered ALU with flags and estado-selected display value.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   sw[DIGIT_W-1:0]         digit on trigger_1/_2, opcode in sw[1:0] on op rise
//   trigger_1, trigger_2    one-cycle append-digit pulses for A / B
//   trigger_op              level, high in operation/result phases
//   estado[1:0]             FSM phase (0 A, 1 B, 2 op select, 3 result)
//   disp_val[W-1:0]         registered display value
//   result[W-1:0]           ALU result register
//   flag_z/n/c/v            zero, negative, carry/borrow, signed overflow
//   result_valid            result/flags hold a computed value
module calc_datapath #(
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 4,
  parameter int W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               trigger_1,
  input  logic               trigger_2,
  input  logic               trigger_op,
  input  logic [1:0]         estado,
  output logic [W-1:0]       disp_val,
  output logic [W-1:0]       result,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c,
  output logic               flag_v,
  output logic               result_valid
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;
  logic [1:0]    opc_q, opc_d;
  logic [W-1:0]  res_q, res_d;
  logic          z_q, z_d, n_q, n_d;
  logic          c_q, c_d, v_q, v_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  disp_q, disp_d;
  logic          trig_op_q;
  logic [1:0]    estado_q;
  logic          comp_q, comp_d;

  logic          rise, new_calc, app_a, app_b;
  logic [W:0]    sum, diff;
  logic [W-1:0]  alu_r;
  logic          alu_c, alu_v;

  assign rise     = trigger_op & ~trig_op_q;
  assign new_calc = (estado_q == 2'd3) && (estado == 2'd0);
  assign app_a    = trigger_1 & ~trigger_op & (cnt_a_q < CNT_MAX);
  assign app_b    = trigger_2 & ~trigger_op & (cnt_b_q < CNT_MAX);

  assign sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
  // Bit W of the extended difference is the unsigned borrow (A < B).
  assign diff = {1'b0, op_a_q} - {1'b0, op_b_q};

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (opc_q)
      2'b00: begin
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (op_a_q[W-1] == op_b_q[W-1]) &&
                (alu_r[W-1] != op_a_q[W-1]);
      end
      2'b01: begin
        alu_r = diff[W-1:0];
        alu_c = diff[W];
        alu_v = (op_a_q[W-1] != op_b_q[W-1]) &&
                (alu_r[W-1] != op_a_q[W-1]);
      end
      2'b10: alu_r = op_a_q & op_b_q;
      2'b11: alu_r = op_a_q | op_b_q;
    endcase
  end

  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    opc_d   = opc_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    valid_d = valid_q;
    comp_d  = 1'b0;
    if (new_calc) begin
      op_a_d  = '0;
      op_b_d  = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      opc_d   = '0;
      res_d   = '0;
      z_d     = 1'b0;
      n_d     = 1'b0;
      c_d     = 1'b0;
      v_d     = 1'b0;
      valid_d = 1'b0;
    end else begin
      if (app_a) begin
        op_a_d  = {op_a_q[W-DIGIT_W-1:0], sw};
        cnt_a_d = cnt_a_q + CNT_ONE;
      end
      if (app_b) begin
        op_b_d  = {op_b_q[W-DIGIT_W-1:0], sw};
        cnt_b_d = cnt_b_q + CNT_ONE;
      end
      if (rise) begin
        opc_d  = sw[1:0];
        comp_d = 1'b1;
      end
      // Compute one cycle after the rise, once the opcode is registered.
      if (comp_q) begin
        res_d   = alu_r;
        z_d     = (alu_r == '0);
        n_d     = alu_r[W-1];
        c_d     = alu_c;
        v_d     = alu_v;
        valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    disp_d = '0;
    unique case (estado)
      2'd0: disp_d = op_a_q;
      2'd1: disp_d = op_b_q;
      2'd2: disp_d = {{(W-2){1'b0}}, sw[1:0]};
      2'd3: disp_d = valid_q ? res_q : '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      opc_q     <= '0;
      res_q     <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      valid_q   <= 1'b0;
      disp_q    <= '0;
      trig_op_q <= 1'b0;
      estado_q  <= '0;
      comp_q    <= 1'b0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      opc_q     <= opc_d;
      res_q     <= res_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
      v_q       <= v_d;
      valid_q   <= valid_d;
      disp_q    <= disp_d;
      trig_op_q <= trigger_op;
      estado_q  <= estado;
      comp_q    <= comp_d;
    end
  end

  assign disp_val     = disp_q;
  assign result       = res_q;
  assign flag_z       = z_q;
  assign flag_n       = n_q;
  assign flag_c       = c_q;
  assign flag_v       = v_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: directed entry/op sequences, result scoreboard
// checked by an independent monitor on each result_valid rise.
module tb_calc_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = '0;
  logic        trigger_1 = 1'b0;
  logic        trigger_2 = 1'b0;
  logic        trigger_op = 1'b0;
  logic [1:0]  estado = '0;
  logic [15:0] disp_val, result;
  logic        flag_z, flag_n, flag_c, flag_v, result_valid;

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;
  logic rv_prev = 1'b0;

  // {result, z, n, c, v}
  logic [19:0] exp_q[$];

  calc_datapath dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .trigger_1(trigger_1), .trigger_2(trigger_2),
    .trigger_op(trigger_op), .estado(estado),
    .disp_val(disp_val), .result(result),
    .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: pop and compare on each rising result_valid.
  always @(negedge clk) begin
    if (!done && rst_n) begin
      if (result_valid && !rv_prev) begin
        logic [19:0] got, exp;
        got = {result, flag_z, flag_n, flag_c, flag_v};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got=%h expected=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL result_flags: got=%h expected=%h", got, exp);
          end
        end
      end
    end
    rv_prev <= result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input bit b, input logic [3:0] d);
    sw = d;
    if (b) trigger_2 = 1'b1;
    else   trigger_1 = 1'b1;
    tick();
    trigger_1 = 1'b0;
    trigger_2 = 1'b0;
  endtask

  // Enter ndig nibbles of v (most significant first) into A (b=0) or B.
  task automatic enter(input bit b, input logic [15:0] v, input int ndig);
    logic [15:0] t;
    estado = b ? 2'd1 : 2'd0;
    t = v;
    for (int i = ndig - 1; i >= 0; i--) begin
      digit(b, 4'(t >> (4 * i)));
    end
    tick();
    tick();
  endtask

  // Select op, raise trigger_op, show result, then start a new calc.
  // inj: also pulse trigger_1 on the rise cycle; it must be ignored.
  task automatic run_op(input logic [1:0] opc, input logic [19:0] exp,
                        input bit inj, input string name);
    estado = 2'd2;
    sw = {2'b00, opc};
    tick();
    exp_q.push_back(exp);
    trigger_op = 1'b1;
    if (inj) trigger_1 = 1'b1;
    tick();
    trigger_1 = 1'b0;
    tick();
    estado = 2'd3;
    tick();
    tick();
    tick();
    chk({name, "_disp"}, {16'h0, disp_val}, {16'h0, exp[19:4]});
    chk({name, "_valid"}, {31'h0, result_valid}, 32'h1);
    estado = 2'd0;
    trigger_op = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp", {16'h0, disp_val}, 32'h0);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_flags_valid",
        {27'h0, flag_z, flag_n, flag_c, flag_v, result_valid}, 32'h0);
    rst_n = 1'b1;
    tick();

    enter(1'b0, 16'h1234, 4);
    chk("a_1234", {16'h0, disp_val}, 32'h1234);
    digit(1'b0, 4'h5);
    tick();
    chk("a_saturate", {16'h0, disp_val}, 32'h1234);
    enter(1'b1, 16'hFFFF, 4);
    chk("b_ffff", {16'h0, disp_val}, 32'hFFFF);

    estado = 2'd2;
    sw = 4'h6;
    tick();
    tick();
    chk("op_preview", {16'h0, disp_val}, 32'h2);

    // 0x1234 + 0xFFFF = 0x1233, carry out
    run_op(2'b00, {16'h1233, 4'b0010}, 1'b0, "add1");
    chk("clr_disp", {16'h0, disp_val}, 32'h0);
    chk("clr_valid", {31'h0, result_valid}, 32'h0);

    // 1 - 2 = 0xFFFF, borrow, negative
    enter(1'b0, 16'h0001, 4);
    enter(1'b1, 16'h0002, 4);
    run_op(2'b01, {16'hFFFF, 4'b0110}, 1'b0, "sub");

    // 0x7FFF + 1 = 0x8000, signed overflow
    enter(1'b0, 16'h7FFF, 4);
    enter(1'b1, 16'h0001, 4);
    run_op(2'b00, {16'h8000, 4'b0101}, 1'b0, "add_ovf");

    // A entered as two digits so a stray trigger_1 would shift it
    enter(1'b0, 16'h00F0, 2);
    chk("a_00f0", {16'h0, disp_val}, 32'h00F0);
    enter(1'b1, 16'h0F0F, 4);
    run_op(2'b10, {16'h0000, 4'b1000}, 1'b1, "and");

    enter(1'b0, 16'h00F0, 4);
    enter(1'b1, 16'h0F0F, 4);
    run_op(2'b11, {16'h0FFF, 4'b0000}, 1'b0, "or");
    chk("clr_result", {16'h0, result}, 32'h0);

    enter(1'b0, 16'h0012, 2);
    chk("a_0012", {16'h0, disp_val}, 32'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_disp", {16'h0, disp_val}, 32'h0);
    chk("async_rest",
        {11'h0, result, flag_z, flag_n, flag_c, flag_v, result_valid}, 32'h0);

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_datapath.md
Name: calc_datapath

Overview:
- Operand/result datapath driven by the calculator control FSM.
- Sits directly downstream of that FSM and consumes its trigger_1, trigger_2, trigger_op and estado outputs.
- Accumulates two multi-digit hex operands nibble-by-nibble, latches an opcode and computes a registered ALU result with flags.
- Presents the value selected by estado to the display driver.

Parameters:
DIGIT_W, 4, bits per entered digit (switch nibble width)
N_DIGITS, 4, maximum digits per operand
W, 16, operand/result width; must equal DIGIT_W*N_DIGITS

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
sw  in  DIGIT_W  switch value: digit on trigger_1/trigger_2, opcode (sw[1:0]) on trigger_op rise
trigger_1  in  1  one-cycle pulse: append sw as next digit of operand A
trigger_2  in  1  one-cycle pulse: append sw as next digit of operand B
trigger_op  in  1  level, high while FSM is in operation/result phases
estado  in  2  FSM phase: 0 entering A, 1 entering B, 2 operation select, 3 show result
disp_val  out  W  value for display (registered)
result  out  W  ALU result register
flag_z  out  1  result == 0
flag_n  out  1  result[W-1]
flag_c  out  1  ADD: carry out; SUB: borrow (A < B unsigned); logic ops: 0
flag_v  out  1  signed overflow for ADD/SUB; 0 for logic ops
result_valid  out  1  result/flags hold a computed value

Behaviour:
- Reset (rst_n low, async): op_a, op_b, cnt_a, cnt_b, opcode, result, all flags, result_valid, disp_val, trig_op_d, estado_d = 0.
- Digit entry:
  - trigger_1 high and cnt_a < N_DIGITS: op_a <= {op_a[W-DIGIT_W-1:0], sw}; cnt_a++ next cycle.
  - trigger_1 with cnt_a == N_DIGITS: ignored; cnt_a saturates.
  - trigger_2 and op_b/cnt_b: identical rules.
  - trigger_1 and trigger_2 high in the same cycle: each applied independently.
  - trigger_1/trigger_2 while trigger_op high: ignored.
- Opcode/compute:
  - Registered trig_op_d detects rising edge of trigger_op.
  - On rise cycle: opcode <= sw[1:0]; 00 ADD, 01 SUB (A-B), 10 AND, 11 OR.
  - Compute stage: 1 cycle after the rise, result and flags load from op_a/op_b/opcode, and result_valid <= 1.
  - Latency: trigger_op rise at cycle N -> result/flags/result_valid valid at N+2 (observed after edge N+1 register).
  - While trigger_op stays high, result holds; no recompute.
  - Arithmetic is modulo 2^W.
  - flag_v for ADD: operand signs equal and result sign differs.
  - flag_v for SUB: operand signs differ and result sign differs from A.
- New calculation: registered estado_d; estado transition 3 -> 0 clears op_a, op_b, cnt_a, cnt_b, opcode, result, flags and result_valid on the next edge.
- Display: disp_val registered each cycle (1-cycle latency from estado change):
  - estado 0 -> op_a
  - estado 1 -> op_b
  - estado 2 -> {W-2 zeros, sw[1:0]}: live opcode preview
  - estado 3 -> result if result_valid, else 0
- Reset mid-operation returns everything to reset values immediately, independent of clk.
- No other state machine: the block is a passive slave of the FSM and never stalls it.

Test Plan:
- Reset, then trigger_1 pulses with sw = 1,2,3,4 and estado=0 -> op_a=0x1234, disp_val=0x1234 one cycle later, cnt_a=4.
- A fifth trigger_1 with sw=5 -> op_a remains 0x1234; then trigger_2 pulses with sw = F,F,F,F and estado=1 -> op_b=0xFFFF.
- A=0x1234, B=0xFFFF, trigger_op rises with sw[1:0]=00 -> two cycles later result=0x1233, flag_c=1, flag_v=0, flag_z=0, result_valid=1; estado=3 -> disp_val=0x1233.
- A=0x0001, B=0x0002, SUB -> result=0xFFFF, flag_c=1 (borrow), flag_n=1, flag_v=0.
- A=0x7FFF, B=0x0001, ADD -> result=0x8000, flag_v=1, flag_n=1, flag_c=0.
- Then A=0x00F0, B=0x0F0F, AND -> result=0, flag_z=1. estado 3 -> 0 -> all operands/result clear. Assert rst_n low mid-entry (op_a=0x0012) -> all outputs 0 asynchronously.
